// File: rtl/mem_port_scheduler_if.sv
// Bundle of the three requester ports, the shared memory port and the status
// outputs of mem_port_scheduler.
interface mem_port_scheduler_if #(
  parameter int ADDR_W = 25
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_wdata;
  logic              dl_ack;

  logic              nv_req;
  logic              nv_we;
  logic [ADDR_W-1:0] nv_addr;
  logic [7:0]        nv_wdata;
  logic [7:0]        nv_rdata;
  logic              nv_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rd;
  logic              mem_we;
  logic              mem_ready;
  logic [7:0]        mem_rdata;

  logic              busy;
  logic              timeout_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dl_req, dl_addr, dl_wdata,
    output dl_ack,
    input  nv_req, nv_we, nv_addr, nv_wdata,
    output nv_rdata, nv_ack,
    output mem_addr, mem_wdata, mem_rd, mem_we,
    input  mem_ready, mem_rdata,
    output busy, timeout_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dl_req, dl_addr, dl_wdata,
    input  dl_ack,
    output nv_req, nv_we, nv_addr, nv_wdata,
    input  nv_rdata, nv_ack,
    input  mem_addr, mem_wdata, mem_rd, mem_we,
    output mem_ready, mem_rdata,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// Arbitrates CPU, download and NVRAM-backup requesters onto one shared
// byte-wide memory port, one transaction in flight at a time.
module mem_port_scheduler #(
  parameter int ADDR_W    = 25,
  parameter int TIMEOUT   = 255,
  parameter int CPU_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_scheduler_if.slave bus
);

  localparam int BURST_W = $clog2(CPU_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ID_CPU = 2'd0,
    ID_DL  = 2'd1,
    ID_NV  = 2'd2
  } port_id_t;

  state_t             state_r, state_nxt_s;
  port_id_t           gnt_id_r, gnt_id_nxt_s;
  logic               we_r, we_nxt_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_nxt_s;
  logic [7:0]         mem_wdata_r, mem_wdata_nxt_s;
  logic [BURST_W-1:0] burst_r, burst_nxt_s;
  logic [7:0]         tmo_cnt_r, tmo_cnt_nxt_s;
  logic               last_nv_r, last_nv_nxt_s;
  logic               timeout_err_r, timeout_err_nxt_s;
  logic               mem_rd_r, mem_rd_nxt_s;
  logic               mem_we_r, mem_we_nxt_s;
  logic               cpu_ack_r, cpu_ack_nxt_s;
  logic               dl_ack_r, dl_ack_nxt_s;
  logic               nv_ack_r, nv_ack_nxt_s;
  logic [7:0]         cpu_rdata_r, cpu_rdata_nxt_s;
  logic [7:0]         nv_rdata_r, nv_rdata_nxt_s;
  logic               busy_r;

  logic               any_req_s;
  logic               burst_full_s;
  logic               cpu_wins_s;
  logic               pick_nv_s;
  logic [7:0]         cap_data_s;

  // Grant decision: CPU first unless its burst is used up while DL/NV wait;
  // DL/NV alternate, DL preferred when NV was served last.
  always_comb begin
    any_req_s    = bus.cpu_req | bus.dl_req | bus.nv_req;
    burst_full_s = (burst_r == BURST_W'(CPU_BURST));
    cpu_wins_s   = bus.cpu_req & ~(burst_full_s & (bus.dl_req | bus.nv_req));
    pick_nv_s    = bus.nv_req & (~bus.dl_req | ~last_nv_r);
    cap_data_s   = bus.mem_ready ? bus.mem_rdata : 8'hFF;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt_s       = state_r;
    gnt_id_nxt_s      = gnt_id_r;
    we_nxt_s          = we_r;
    mem_addr_nxt_s    = mem_addr_r;
    mem_wdata_nxt_s   = mem_wdata_r;
    burst_nxt_s       = burst_r;
    tmo_cnt_nxt_s     = tmo_cnt_r;
    last_nv_nxt_s     = last_nv_r;
    timeout_err_nxt_s = timeout_err_r;
    mem_rd_nxt_s      = 1'b0;
    mem_we_nxt_s      = 1'b0;
    cpu_ack_nxt_s     = 1'b0;
    dl_ack_nxt_s      = 1'b0;
    nv_ack_nxt_s      = 1'b0;
    cpu_rdata_nxt_s   = cpu_rdata_r;
    nv_rdata_nxt_s    = nv_rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
          if (cpu_wins_s) begin
            gnt_id_nxt_s    = ID_CPU;
            we_nxt_s        = bus.cpu_we;
            mem_addr_nxt_s  = bus.cpu_addr;
            mem_wdata_nxt_s = bus.cpu_wdata;
            if (burst_full_s) begin
              burst_nxt_s = burst_r;
            end else begin
              burst_nxt_s = burst_r + BURST_W'(1);
            end
          end else if (pick_nv_s) begin
            gnt_id_nxt_s    = ID_NV;
            we_nxt_s        = bus.nv_we;
            mem_addr_nxt_s  = bus.nv_addr;
            mem_wdata_nxt_s = bus.nv_wdata;
            burst_nxt_s     = '0;
            last_nv_nxt_s   = 1'b1;
          end else begin
            gnt_id_nxt_s    = ID_DL;
            we_nxt_s        = 1'b1;
            mem_addr_nxt_s  = bus.dl_addr;
            mem_wdata_nxt_s = bus.dl_wdata;
            burst_nxt_s     = '0;
            last_nv_nxt_s   = 1'b0;
          end
          // Strobe registered on the grant edge so it is high during ISSUE
          mem_we_nxt_s = we_nxt_s;
          mem_rd_nxt_s = ~we_nxt_s;
        end else begin
          burst_nxt_s = '0;
        end
      end

      ST_ISSUE: begin
        state_nxt_s   = ST_WAIT;
        tmo_cnt_nxt_s = 8'd0;
      end

      ST_WAIT: begin
        // A real mem_ready on the final WAIT cycle wins over the timeout
        if (bus.mem_ready || (tmo_cnt_r == 8'(TIMEOUT - 1))) begin
          state_nxt_s       = ST_DONE;
          timeout_err_nxt_s = timeout_err_r | ~bus.mem_ready;
          case (gnt_id_r)
            ID_CPU: begin
              cpu_ack_nxt_s   = 1'b1;
              cpu_rdata_nxt_s = cap_data_s;
            end
            ID_DL: begin
              dl_ack_nxt_s = 1'b1;
            end
            ID_NV: begin
              nv_ack_nxt_s   = 1'b1;
              nv_rdata_nxt_s = cap_data_s;
            end
            default: begin
              dl_ack_nxt_s = 1'b0;
            end
          endcase
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      gnt_id_r      <= ID_CPU;
      we_r          <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= 8'd0;
      burst_r       <= '0;
      tmo_cnt_r     <= 8'd0;
      last_nv_r     <= 1'b1;
      timeout_err_r <= 1'b0;
      mem_rd_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      cpu_ack_r     <= 1'b0;
      dl_ack_r      <= 1'b0;
      nv_ack_r      <= 1'b0;
      cpu_rdata_r   <= 8'd0;
      nv_rdata_r    <= 8'd0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      gnt_id_r      <= gnt_id_nxt_s;
      we_r          <= we_nxt_s;
      mem_addr_r    <= mem_addr_nxt_s;
      mem_wdata_r   <= mem_wdata_nxt_s;
      burst_r       <= burst_nxt_s;
      tmo_cnt_r     <= tmo_cnt_nxt_s;
      last_nv_r     <= last_nv_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
      mem_rd_r      <= mem_rd_nxt_s;
      mem_we_r      <= mem_we_nxt_s;
      cpu_ack_r     <= cpu_ack_nxt_s;
      dl_ack_r      <= dl_ack_nxt_s;
      nv_ack_r      <= nv_ack_nxt_s;
      cpu_rdata_r   <= cpu_rdata_nxt_s;
      nv_rdata_r    <= nv_rdata_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.mem_rd      = mem_rd_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.dl_ack      = dl_ack_r;
  assign bus.nv_ack      = nv_ack_r;
  assign bus.nv_rdata    = nv_rdata_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;

endmodule
